sbit_frame_aligner: RTL and testbench
=====================================

# sbit_frame_aligner

Recovers 8-bit S-bit frames from one VFAT trigger unit. Inputs are 8 bit-serial S-bit lanes plus a start-of-frame (SOF) lane, already sampled and phase-aligned by the upstream oversampler. The block deserializes each lane into a frame word, checks SOF periodicity, and presents one parallel S-bit word per frame. It sits between the per-pin oversamplers and the S-bit cluster logic, with one instance per VFAT.

## Interface
- `MXSBITS`, default 64: output S-bits per VFAT; must be a multiple of 8.
- `NLANES`, default `MXSBITS/8`: number of serial lanes; derived, not overridden.

Ports:
- `clock`  in  1  bit-rate clock (one bit per lane per cycle).
- `reset_i`  in  1  reset, synchronous, active-high.
- `d0`  in  NLANES  sampled serial data; bit `k` is lane `k`.
- `start_of_frame`  in  1  sampled SOF lane; high on the cycle carrying bit 0 of a frame.
- `mask`  in  1  1 forces `sbits` to zero.
- `sbits`  out  MXSBITS  frame word; `sbits[lane*8+b]` = bit `b` of `lane`.
- `sof_delayed`  out  1  one-cycle strobe; `sbits` updated this cycle with a complete frame.
- `alignment_error`  out  1  sticky SOF-periodicity error flag.

Clocking and reset are decided: one clock; reset is synchronous and active-high, on ports `clock` and `reset_i`.

## Operation
- **Bit position.**
  - `pos` is the bit position of the current cycle. If `start_of_frame`=1, `pos`=0; otherwise `pos` = counter value.
  - Each cycle the 3-bit counter loads `pos+1` (mod 8).
- **Lock.**
  - `locked` clears on reset.
  - It sets on the first cycle with `start_of_frame`=1.
  - Before lock, no data is captured and no frames are emitted.
- **Capture.**
  - While locked, or on the lock cycle itself, each cycle writes `shift[lane][pos]` <= `d0[lane]` for every lane.
  - Bit 0 is the bit coincident with SOF; bits are LSB-first in time.
- **Frame complete.** On a cycle with `pos`=7 and `valid_frame`=1, the next cycle does all of the following:
  - `sbits` <= the assembled bits; the bit-7 column comes from the current `d0`.
  - `sof_delayed` = 1.
- **valid_frame.**
  - It sets when SOF is seen.
  - It clears when an early SOF truncates a frame. Because the truncating SOF also restarts `pos` at 0, the new frame is valid.
  - Net effect: a partial frame before a resync is discarded and never emitted.
- **Alignment checking** applies while locked:
  - Early SOF: `start_of_frame`=1 while the counter ≠ 0. Set `alignment_error`, drop the partial frame, resync `pos` to 0.
  - Missing SOF: counter = 0 while `start_of_frame`=0. Set `alignment_error` and keep counting (flywheel). That frame is still emitted at `pos`=7.
  - `alignment_error` stays set until `reset_i`.
- **Mask.**
  - While `mask`=1, `sbits` <= 0 every cycle, with priority over frame updates.
  - `sof_delayed` strobes continue.
- **Arithmetic.** The counter is 3 bits and wraps 7 → 0. No other arithmetic.

## Timing
- Reset values: `sbits`=0, `sof_delayed`=0, `alignment_error`=0; internally `locked`=0, counter=0, shift registers=0.
- Latency:
  - Bit 7 sampled at cycle t gives `sbits` and `sof_delayed` valid at cycle t+1.
  - For an SOF at cycle t0, the frame appears at t0+8.
- `sof_delayed` is high exactly 1 cycle per emitted frame. With steady SOF every 8 cycles it is periodic, with period 8.
- `sbits` holds its value between strobes, and is zero while masked.
- Errors:
  - Early SOF at cycle t: `alignment_error` high from t+1.
  - Missing SOF at expected cycle t: `alignment_error` high from t+1.
- Reset mid-frame:
  - All state clears on the next edge and the partial frame is lost.
  - The block needs a fresh SOF to relock. Any SOF in the reset cycle is ignored.
- Simultaneous `mask`=1 and frame complete: `sbits` becomes 0, and `sof_delayed` is still 1.

## Test plan
1. **Steady frames.** After reset, SOF every 8 cycles.
   - Lane 0 sends 0xA5 LSB-first; lane 7 sends 0x3C; other lanes send 0.
   - Required at 8 cycles after each SOF: `sbits[7:0]`=0xA5, `sbits[63:56]`=0x3C, `sof_delayed`=1 for one cycle, `alignment_error`=0.
2. **No SOF.**
   - Toggle `d0` for 40 cycles without any SOF.
   - Required: `sbits`=0, `sof_delayed` never asserts, `alignment_error`=0.
3. **Early SOF.**
   - Lock, then send the next SOF 5 cycles after the previous one.
   - Required: `alignment_error`=1 from the following cycle; no strobe for the truncated frame; the next frame is emitted 8 cycles after the early SOF with correct data.
4. **Missing SOF.**
   - Lock, then omit one SOF.
   - Required: `alignment_error`=1 one cycle after the expected position; a strobe still occurs at +8 with the data captured by the flywheel counter.
5. **Mask.**
   - Steady frames of 0xFF on all lanes; assert `mask`.
   - Required: `sbits`=0 from the next cycle, strobes continue; deassert `mask` and the next frame shows all ones.
6. **Reset mid-frame.**
   - Pulse `reset_i` at bit 4 of a frame.
   - Required: all outputs 0 next cycle, including clearing a previously set `alignment_error`; no emission until 8 cycles after the next SOF.

Source files
------------

// File: rtl/sbit_frame_aligner.sv
// S-bit frame aligner: deserializes NLANES serial S-bit lanes into one
// parallel word per 8-bit frame, tracking SOF periodicity.
module sbit_frame_aligner #(
    parameter int MXSBITS = 64,
    parameter int NLANES  = MXSBITS / 8
) (
    input  logic               clock,
    input  logic               reset_i,
    input  logic [NLANES-1:0]  d0,
    input  logic               start_of_frame,
    input  logic               mask,
    output logic [MXSBITS-1:0] sbits,
    output logic               sof_delayed,
    output logic               alignment_error
);

    logic [2:0]                   cnt_q;
    logic                         locked_q;
    logic [NLANES-1:0][6:0]       shift_q;
    logic [NLANES-1:0][6:0]       shift_d;
    logic [MXSBITS-1:0]           sbits_q;
    logic                         sof_q;
    logic                         err_q;

    logic [2:0]                   pos;
    logic                         capture;
    logic                         frame_done;
    logic                         early_sof;
    logic                         missing_sof;
    logic [MXSBITS-1:0]           frame_word;

    always_comb begin
        pos         = start_of_frame ? 3'd0 : cnt_q;
        capture     = locked_q || start_of_frame;
        // An early SOF restarts pos, so a truncated frame never reaches pos 7.
        frame_done  = locked_q && (pos == 3'd7);
        early_sof   = locked_q && start_of_frame && (cnt_q != 3'd0);
        missing_sof = locked_q && !start_of_frame && (cnt_q == 3'd0);

        shift_d = shift_q;
        if (capture) begin
            for (int l = 0; l < NLANES; l++) begin
                for (int b = 0; b < 7; b++) begin
                    if (pos == 3'(b)) begin
                        shift_d[l][b] = d0[l];
                    end
                end
            end
        end

        // Bit 7 is taken straight from the lane on the completing cycle.
        frame_word = '0;
        for (int l = 0; l < NLANES; l++) begin
            frame_word[l*8 +: 7] = shift_q[l];
            frame_word[l*8 + 7]  = d0[l];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            cnt_q    <= 3'd0;
            locked_q <= 1'b0;
            shift_q  <= '0;
            sbits_q  <= '0;
            sof_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q   <= pos + 3'd1;
            shift_q <= shift_d;
            sof_q   <= frame_done;
            if (start_of_frame) begin
                locked_q <= 1'b1;
            end
            if (early_sof || missing_sof) begin
                err_q <= 1'b1;
            end
            if (mask) begin
                sbits_q <= '0;
            end else if (frame_done) begin
                sbits_q <= frame_word;
            end
        end
    end

    assign sbits           = sbits_q;
    assign sof_delayed     = sof_q;
    assign alignment_error = err_q;

endmodule

// File: tb/tb_sbit_frame_aligner.sv
// Directed bench for sbit_frame_aligner: steady frames, no SOF,
// early/missing SOF, mask and mid-frame reset.
module tb_sbit_frame_aligner;

    logic        clock = 1'b0;
    logic        reset_i;
    logic [7:0]  d0;
    logic        start_of_frame;
    logic        mask;
    logic [63:0] sbits;
    logic        sof_delayed;
    logic        alignment_error;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int snap;

    sbit_frame_aligner #(.MXSBITS(64)) dut (
        .clock           (clock),
        .reset_i         (reset_i),
        .d0              (d0),
        .start_of_frame  (start_of_frame),
        .mask            (mask),
        .sbits           (sbits),
        .sof_delayed     (sof_delayed),
        .alignment_error (alignment_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (sof_delayed) strobes++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] w2(input logic [7:0] l0,
                                       input logic [7:0] l7);
        return {l7, 48'h0, l0};
    endfunction

    task automatic frame(input logic [63:0] w, input bit sof,
                         input int b0, input int b1);
        for (int b = b0; b <= b1; b++) begin
            start_of_frame = sof && (b == 0);
            for (int k = 0; k < 8; k++) d0[k] = w[k*8 + b];
            tick();
        end
        start_of_frame = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        d0 = '0;
        start_of_frame = 1'b0;
        mask = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        chk("rst_sbits", sbits, 64'h0);
        chk("rst_sof", {63'h0, sof_delayed}, 64'h0);
        chk("rst_err", {63'h0, alignment_error}, 64'h0);

        // No SOF: lanes toggle but nothing locks
        snap = strobes;
        for (int i = 0; i < 40; i++) begin
            d0 = i[0] ? 8'hFF : 8'h5A;
            tick();
        end
        chk("nosof_sbits", sbits, 64'h0);
        chk("nosof_strobes", 64'(strobes - snap), 64'h0);
        chk("nosof_err", {63'h0, alignment_error}, 64'h0);

        // Steady frames
        snap = strobes;
        for (int f = 0; f < 3; f++) begin
            frame(w2(8'hA5, 8'h3C), 1'b1, 0, 7);
            chk("steady_sbits", sbits, w2(8'hA5, 8'h3C));
            chk("steady_sof", {63'h0, sof_delayed}, 64'h1);
            chk("steady_err", {63'h0, alignment_error}, 64'h0);
        end
        chk("steady_strobes", 64'(strobes - snap), 64'h3);

        // Early SOF: 5-bit frame, then a fresh SOF
        snap = strobes;
        frame(w2(8'h11, 8'h22), 1'b1, 0, 0);
        chk("sof_one_cycle", {63'h0, sof_delayed}, 64'h0);
        frame(w2(8'h11, 8'h22), 1'b0, 1, 4);
        chk("early_pre_err", {63'h0, alignment_error}, 64'h0);
        frame(w2(8'h5A, 8'hC3), 1'b1, 0, 0);
        chk("early_err", {63'h0, alignment_error}, 64'h1);
        chk("early_hold", sbits, w2(8'hA5, 8'h3C));
        frame(w2(8'h5A, 8'hC3), 1'b0, 1, 7);
        chk("early_sbits", sbits, w2(8'h5A, 8'hC3));
        chk("early_sof", {63'h0, sof_delayed}, 64'h1);
        chk("early_strobes", 64'(strobes - snap), 64'h1);

        // Reset at bit 4, with an SOF in the reset cycle that must be ignored
        frame(w2(8'h77, 8'h88), 1'b1, 0, 3);
        reset_i = 1'b1;
        start_of_frame = 1'b1;
        tick();
        reset_i = 1'b0;
        start_of_frame = 1'b0;
        chk("mrst_sbits", sbits, 64'h0);
        chk("mrst_sof", {63'h0, sof_delayed}, 64'h0);
        chk("mrst_err", {63'h0, alignment_error}, 64'h0);
        snap = strobes;
        for (int i = 0; i < 10; i++) begin
            d0 = 8'hFF;
            tick();
        end
        chk("mrst_nolock_err", {63'h0, alignment_error}, 64'h0);
        chk("mrst_nolock_strobes", 64'(strobes - snap), 64'h0);
        frame(w2(8'h96, 8'h69), 1'b1, 0, 7);
        chk("relock_sbits", sbits, w2(8'h96, 8'h69));
        chk("relock_strobes", 64'(strobes - snap), 64'h1);
        chk("relock_err", {63'h0, alignment_error}, 64'h0);

        // Missing SOF: flywheel keeps framing
        frame(w2(8'h0F, 8'hF0), 1'b0, 0, 0);
        chk("miss_err", {63'h0, alignment_error}, 64'h1);
        frame(w2(8'h0F, 8'hF0), 1'b0, 1, 7);
        chk("miss_sbits", sbits, w2(8'h0F, 8'hF0));
        chk("miss_sof", {63'h0, sof_delayed}, 64'h1);

        // Mask
        frame({64{1'b1}}, 1'b1, 0, 7);
        chk("mask_pre", sbits, {64{1'b1}});
        mask = 1'b1;
        frame({64{1'b1}}, 1'b1, 0, 0);
        chk("mask_zero", sbits, 64'h0);
        frame({64{1'b1}}, 1'b0, 1, 7);
        chk("mask_done_sbits", sbits, 64'h0);
        chk("mask_done_sof", {63'h0, sof_delayed}, 64'h1);
        mask = 1'b0;
        frame({64{1'b1}}, 1'b1, 0, 0);
        chk("unmask_hold", sbits, 64'h0);
        frame({64{1'b1}}, 1'b0, 1, 7);
        chk("unmask_sbits", sbits, {64{1'b1}});
        chk("unmask_sof", {63'h0, sof_delayed}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
